// File: rtl/weight_loader_pkg.sv
// Shared constants, FSM state type and checksum rule for the weight loader.
// The loader and the threshold network both depend on these widths.
package weight_loader_pkg;

  localparam int W_BITS      = 4;
  localparam int N_W         = 9;
  localparam int FRAME_BEATS = N_W + 1;
  localparam int IDX_BITS    = 4;
  localparam logic [W_BITS-1:0] RESET_W = '0;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    CHECK = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Running checksum: unsigned sum of weight nibbles, wrapping at 2^W_BITS.
  function automatic logic [W_BITS-1:0] checksum_add(input logic [W_BITS-1:0] sum,
                                                     input logic [W_BITS-1:0] nibble);
    return sum + nibble;
  endfunction

endpackage

// File: rtl/weight_loader.sv
// Collects a nibble-serial weight frame into a shadow buffer, verifies its
// checksum and commits all nine weights to the output bank in one edge.
module weight_loader
  import weight_loader_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [W_BITS-1:0]        in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic signed [W_BITS-1:0] w0,
  output logic signed [W_BITS-1:0] w1,
  output logic signed [W_BITS-1:0] w2,
  output logic signed [W_BITS-1:0] w3,
  output logic signed [W_BITS-1:0] w4,
  output logic signed [W_BITS-1:0] w5,
  output logic signed [W_BITS-1:0] w6,
  output logic signed [W_BITS-1:0] w7,
  output logic signed [W_BITS-1:0] w8,
  output logic                     weights_valid,
  output logic                     load_done,
  output logic                     load_err,
  output logic                     busy
);

  state_t              state_q, state_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [W_BITS-1:0]   sum_q, sum_d;
  logic                match_q, match_d;
  logic [W_BITS-1:0]   shadow_q [N_W];
  logic [W_BITS-1:0]   shadow_d [N_W];
  logic [W_BITS-1:0]   w_q [N_W];
  logic [W_BITS-1:0]   w_d [N_W];
  logic                wv_q, wv_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                accept;

  assign in_ready = (state_q != CHECK);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    match_d  = match_q;
    shadow_d = shadow_q;
    w_d      = w_q;
    wv_d     = wv_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      RECV: begin
        if (accept) begin
          if (idx_q == IDX_BITS'(FRAME_BEATS - 1)) begin
            if (in_last) begin
              match_d = (in_data == sum_q);
              state_d = CHECK;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (in_last) begin
            // Early end of frame: the frame is already closed, so no drain.
            err_d = 1'b1;
            idx_d = '0;
            sum_d = '0;
          end else begin
            for (int i = 0; i < N_W; i++) begin
              if (idx_q == IDX_BITS'(i)) shadow_d[i] = in_data;
            end
            sum_d = checksum_add(sum_q, in_data);
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (match_q) begin
          w_d    = shadow_q;
          wv_d   = 1'b1;
          done_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        idx_d   = '0;
        sum_d   = '0;
        state_d = RECV;
      end
      DRAIN: begin
        if (accept && in_last) begin
          idx_d   = '0;
          sum_d   = '0;
          state_d = RECV;
        end
      end
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RECV;
      idx_q   <= '0;
      sum_q   <= '0;
      match_q <= 1'b0;
      wv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_W; i++) begin
        shadow_q[i] <= '0;
        w_q[i]      <= RESET_W;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
      match_q  <= match_d;
      wv_q     <= wv_d;
      done_q   <= done_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      w_q      <= w_d;
    end
  end

  assign w0 = w_q[0];
  assign w1 = w_q[1];
  assign w2 = w_q[2];
  assign w3 = w_q[3];
  assign w4 = w_q[4];
  assign w5 = w_q[5];
  assign w6 = w_q[6];
  assign w7 = w_q[7];
  assign w8 = w_q[8];

  assign weights_valid = wv_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign busy          = (idx_q != '0) || (state_q != RECV);

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: a table of whole frames with expected
// outcomes, plus hand sequences for drain, back-to-back and mid-frame reset.
module tb_weight_loader;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [3:0] in_data;
  logic in_last;
  logic in_ready;
  logic signed [3:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic weights_valid, load_done, load_err, busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  weight_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8),
    .weights_valid(weights_valid), .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  // Frames: nibble i of a frame lives at bits [4*i +: 4]; beat 9 is the checksum.
  localparam logic [39:0] XOR_OK  = 40'h1111DEE122;
  localparam logic [39:0] XOR_BAD = 40'h2111DEE122;
  localparam logic [39:0] SET2_OK = 40'hD987654321;
  localparam logic [35:0] W_XOR   = 36'h111DEE122;
  localparam logic [35:0] W_SET2  = 36'h987654321;
  localparam logic [35:0] W_RST   = 36'h000000000;

  typedef struct {
    logic [39:0] beats;
    int          last_at;
    logic        exp_done;
    logic        exp_err;
    logic [35:0] exp_w;
    logic        exp_wv;
  } rec_t;

  rec_t vec [7];

  logic [35:0] w_bus;
  assign w_bus = {w8, w7, w6, w5, w4, w3, w2, w1, w0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one beat and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send_beat(input logic [3:0] d, input logic last);
    int waited;
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    waited   = 0;
    ok       = 0;
    while (!ok && waited < 20) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!ok) chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [39:0] beats, input int last_at);
    logic [39:0] b;
    b = beats;
    for (int i = 0; i <= last_at; i++) send_beat(b[4*i +: 4], i == last_at);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Threshold node: fires when the weighted input sum exceeds the bias weight.
  function automatic logic node(input logic signed [3:0] wa, input logic signed [3:0] wb,
                                input logic signed [3:0] th, input logic a, input logic b);
    int s;
    s = (a ? int'(wa) : 0) + (b ? int'(wb) : 0);
    return s > int'(th);
  endfunction

  logic saw_done, saw_err, ya, yb, y;
  logic [3:0] beat_q [20];
  logic [39:0] fb;
  int ptr, cyc, nlow, d1, d2, err_cnt;
  bit acc;

  initial begin
    vec[0] = '{XOR_BAD, 9, 1'b0, 1'b1, W_RST,  1'b0};
    vec[1] = '{SET2_OK, 4, 1'b0, 1'b1, W_RST,  1'b0};
    vec[2] = '{XOR_OK,  9, 1'b1, 1'b0, W_XOR,  1'b1};
    vec[3] = '{XOR_BAD, 9, 1'b0, 1'b1, W_XOR,  1'b1};
    vec[4] = '{SET2_OK, 9, 1'b1, 1'b0, W_SET2, 1'b1};
    vec[5] = '{XOR_OK,  4, 1'b0, 1'b1, W_SET2, 1'b1};
    vec[6] = '{XOR_OK,  9, 1'b1, 1'b0, W_XOR,  1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 4'h0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_w", 64'(w_bus), 64'(W_RST));
    chk("rst_wv", 64'(weights_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_err", 64'(load_err), 64'd0);

    // Table of whole frames.
    for (int r = 0; r < 7; r++) begin
      send_frame(vec[r].beats, vec[r].last_at);
      saw_done = load_done;
      saw_err  = load_err;
      if (vec[r].last_at == 9) chk($sformatf("v%0d_check_ready", r), 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      saw_done |= load_done;
      saw_err  |= load_err;
      chk($sformatf("v%0d_done", r), 64'(saw_done), 64'(vec[r].exp_done));
      chk($sformatf("v%0d_err", r), 64'(saw_err), 64'(vec[r].exp_err));
      chk($sformatf("v%0d_w", r), 64'(w_bus), 64'(vec[r].exp_w));
      chk($sformatf("v%0d_wv", r), 64'(weights_valid), 64'(vec[r].exp_wv));
      chk($sformatf("v%0d_busy", r), 64'(busy), 64'd0);
      $display("frame %0d: last_at=%0d done=%0b err=%0b w=%h wv=%0b",
               r, vec[r].last_at, saw_done, saw_err, w_bus, weights_valid);
    end

    // Loaded XOR weights drive the network to y = x0 ^ x1.
    for (int x = 0; x < 4; x++) begin
      ya = node(w0, w1, w2, x[0], x[1]);
      yb = node(w3, w4, w5, x[0], x[1]);
      y  = node(w6, w7, w8, ya, yb);
      chk($sformatf("net_x%0d", x), 64'(y), 64'(x[0] ^ x[1]));
      $display("network x=%0d%0d y=%0b", x[1], x[0], y);
    end

    // Checksum beat without in_last, then three junk beats.
    fb = XOR_OK;
    for (int i = 0; i < 9; i++) send_beat(fb[4*i +: 4], 1'b0);
    send_beat(4'h1, 1'b0);
    err_cnt = 0;
    if (load_err) err_cnt++;
    chk("drain_enter_ready", 64'(in_ready), 64'd1);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("drain_ready_%0d", j), 64'(in_ready), 64'd1);
      send_beat(4'h7, j == 2);
      if (load_err) err_cnt++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1;
    if (load_err || load_done) err_cnt++;
    chk("drain_err_count", 64'(err_cnt), 64'd1);
    chk("drain_w", 64'(w_bus), 64'(W_XOR));
    chk("drain_busy", 64'(busy), 64'd0);
    $display("drain: err pulses=%0d w=%h", err_cnt, w_bus);
    send_frame(SET2_OK, 9);
    @(posedge clk);
    #1;
    chk("after_drain_done", 64'(load_done), 64'd1);
    chk("after_drain_w", 64'(w_bus), 64'(W_SET2));

    // Back-to-back frames with in_valid held high.
    fb = XOR_OK;
    for (int i = 0; i < 10; i++) beat_q[i] = fb[4*i +: 4];
    fb = SET2_OK;
    for (int i = 0; i < 10; i++) beat_q[10+i] = fb[4*i +: 4];
    ptr = 0; cyc = 0; nlow = 0; d1 = -1; d2 = -1;
    while (cyc < 40 && !(ptr == 20 && d2 >= 0)) begin
      if (ptr < 20) begin
        in_valid = 1'b1;
        in_data  = beat_q[ptr];
        in_last  = ((ptr % 10) == 9);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      acc = in_valid && in_ready;
      if (!in_ready) nlow++;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) ptr++;
      if (load_done) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    chk("b2b_ready_low", 64'(nlow), 64'd2);
    chk("b2b_both_done", 64'(d2 >= 0), 64'd1);
    chk("b2b_period", 64'(d2 - d1), 64'd11);
    chk("b2b_w", 64'(w_bus), 64'(W_SET2));
    $display("back-to-back: done at %0d and %0d, ready low %0d cycles", d1, d2, nlow);

    // Reset in the middle of a frame, then a full frame from beat 0.
    fb = XOR_OK;
    for (int i = 0; i < 6; i++) send_beat(fb[4*i +: 4], 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_w", 64'(w_bus), 64'(W_RST));
    chk("mid_rst_wv", 64'(weights_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    send_frame(XOR_OK, 9);
    @(posedge clk);
    #1;
    chk("post_rst_done", 64'(load_done), 64'd1);
    chk("post_rst_w", 64'(w_bus), 64'(W_XOR));
    chk("post_rst_wv", 64'(weights_valid), 64'd1);
    $display("mid-frame reset: recommit w=%h wv=%0b", w_bus, weights_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/weight_loader.md
# weight_loader

Loads one complete weight set for the 2-2-1 threshold network (three nodes, nine signed 4-bit weights w0..w8) from a nibble-serial valid/ready stream. Beats are collected into a shadow buffer, and the frame checksum is verified. On a match, all nine weights are committed atomically to the registered outputs that feed the network's weight ports. It is the writer-side counterpart of the network: the network only reads w0..w8, and this block is the sole producer of them.

## Interface
- W_BITS, 4, weight width (signed two's complement); fixed to match the network
- N_W, 9, weights per frame; frame length is N_W+1 beats
- RESET_W, 0, value of every weight output after reset
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  beat offered
- in_data  in  W_BITS  weight nibble (beats 0..8), then checksum nibble (beat 9)
- in_last  in  1  marks final beat of a frame
- in_ready  out  1  beat accepted when in_valid && in_ready
- w0..w8  out  W_BITS each, signed  committed weights (w0..w2 node A, w3..w5 node B, w6..w8 node C)
- weights_valid  out  1  high once any frame has committed
- load_done  out  1  one-cycle pulse on successful commit
- load_err  out  1  one-cycle pulse on discarded frame
- busy  out  1  frame in progress (beat count ≠ 0 or state ≠ RECV)

## Operation
- States:
  - RECV: in_ready=1. Each accepted beat with index 0..8 is stored in shadow[idx], the running sum is updated (sum += in_data, unsigned mod 16), and idx increments.
  - CHECK: one cycle, in_ready=0.
  - DRAIN: in_ready=1, beats are discarded.
- Beat index 9 (checksum) accepted:
  - With in_last=1: go to CHECK and latch the match result (in_data == sum[3:0]).
  - With in_last=0: framing error. Pulse load_err and go to DRAIN.
- Framing error on early in_last: in_last on an accepted beat with index 0..8. Pulse load_err, clear idx and sum, and stay in RECV. The frame is closed, so no drain is needed.
- CHECK:
  - On match: w0..w8 ← shadow[0..8], all in the same edge. Set weights_valid=1 and pulse load_done.
  - On mismatch: outputs are unchanged, pulse load_err.
  - Either way: clear idx and sum, return to RECV.
- DRAIN: discard beats until an accepted beat has in_last=1, then clear idx and sum and return to RECV.
- Committed weights never change except in CHECK-on-match or on reset. There are no partial updates.
- Reset (including mid-frame): state=RECV, idx=0, sum=0, shadow=0, w0..w8=RESET_W, weights_valid=0, load_done=0, load_err=0. Reset outputs: in_ready=1, busy=0.

## Timing
- Throughput: one beat per cycle while in RECV.
- Checksum beat accepted at edge E:
  - The cycle between E and E+1 is CHECK, with in_ready=0.
  - New weights and the load_done/load_err pulse are visible after edge E+1.
- Pipelining: the next frame's beat 0 can be accepted at edge E+2. Minimum frame period is 11 cycles.
- Framing-error load_err is registered: it is visible in the cycle after the offending beat is accepted.
- in_valid may toggle freely. in_data and in_last are sampled only on accepted beats.
- load_done and load_err are never high together.

## Structure
- Package weight_loader_pkg holds:
  - W_BITS, N_W, FRAME_BEATS = N_W+1
  - state enum {RECV, CHECK, DRAIN}
  - RESET_W default
  - checksum rule: unsigned sum of weight nibbles mod 2^W_BITS
- No sub-module is needed: use a single FSM, a 4-bit index counter, a 4-bit running sum, a shadow array, and an output register bank.

## Test plan
- XOR set, unsigned nibbles 2,2,1,E,E,D,1,1,1 + checksum 1 with in_last on beat 9. Required:
  - load_done pulse 2 edges after the checksum beat.
  - w0..w8 = 2,2,1,-2,-2,-3,1,1,1 and weights_valid=1.
  - Loaded network outputs y=x[0]^x[1].
- Same frame with checksum 2: load_err pulses, weights keep the previous values (RESET_W if first), weights_valid is unchanged.
- in_last on beat 4: load_err the next cycle, busy=0. A following valid frame commits normally.
- Checksum beat without in_last, then 3 junk beats with in_last on the third: load_err once, in_ready=1 throughout DRAIN, no weight change. The next frame succeeds.
- Back-to-back frames with in_valid held high:
  - in_ready=0 exactly one cycle per frame.
  - Second set visible 11 cycles after the first.
- rst_n low mid-frame (after beat 5), then a full valid frame: outputs return to RESET_W and weights_valid=0; the new frame commits from beat 0.
